// File: rtl/instn_decode_pipe_if.sv
// -----------------------------------------------------------------------------
// instn_decode_pipe_if
// Handshake and data bundle between fetch, the decode stage and its consumer.
//   in_*  : fetched beat (valid/ready, lane mask, LANES x 32-bit instructions,
//           PC of lane 0)
//   out_* : decoded beat (valid/ready, lane mask, per-lane decoded fields)
// Modports:
//   slave  : the decode stage (consumes in_*, produces out_*)
//   master : the environment around it (produces in_*, consumes out_*)
// -----------------------------------------------------------------------------
interface instn_decode_pipe_if #(
    parameter int LANES = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [LANES-1:0]      in_lane_valid;
    logic [32*LANES-1:0]   in_instn;
    logic [31:0]           in_pc;

    logic                  out_valid;
    logic                  out_ready;
    logic [LANES-1:0]      out_lane_valid;
    logic [32*LANES-1:0]   out_pc;
    logic [7*LANES-1:0]    out_op;
    logic [3*LANES-1:0]    out_funct3;
    logic [7*LANES-1:0]    out_funct7;
    logic [5*LANES-1:0]    out_rs1;
    logic [5*LANES-1:0]    out_rs2;
    logic [5*LANES-1:0]    out_rd;
    logic [32*LANES-1:0]   out_imm;
    logic [3*LANES-1:0]    out_imm_type;
    logic [LANES-1:0]      out_rs1_used;
    logic [LANES-1:0]      out_rs2_used;
    logic [LANES-1:0]      out_rd_wen;
    logic [LANES-1:0]      out_illegal;

    modport slave (
        input  in_valid, in_lane_valid, in_instn, in_pc, out_ready,
        output in_ready, out_valid, out_lane_valid, out_pc, out_op, out_funct3,
               out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_imm_type,
               out_rs1_used, out_rs2_used, out_rd_wen, out_illegal
    );

    modport master (
        output in_valid, in_lane_valid, in_instn, in_pc, out_ready,
        input  in_ready, out_valid, out_lane_valid, out_pc, out_op, out_funct3,
               out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_imm_type,
               out_rs1_used, out_rs2_used, out_rd_wen, out_illegal
    );
endinterface

// File: rtl/instn_decode_pipe.sv
// -----------------------------------------------------------------------------
// instn_decode_pipe
// Registered RV32I decode stage. Decodes LANES instructions per beat into
// fields, a format-selected sign-extended immediate, register-use flags and an
// illegal flag. Results sit in a main register (M) with a skid register (S)
// behind it so in_ready comes straight from a flop.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset
//   flush   : synchronous kill of every buffered beat and of the input beat
//   bus     : instn_decode_pipe_if.slave (input beat / decoded output beat)
// Parameters:
//   LANES       : instructions per beat (1..4)
//   ILLEGAL_CHK : 1 adds funct3/funct7 legality checks, 0 checks opcode only
// -----------------------------------------------------------------------------
module instn_decode_pipe #(
    parameter int LANES       = 1,
    parameter bit ILLEGAL_CHK = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    instn_decode_pipe_if.slave  bus
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] IMM_R = 3'd0;
    localparam logic [2:0] IMM_I = 3'd1;
    localparam logic [2:0] IMM_S = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;
    localparam logic [2:0] IMM_J = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic        rs1_used;
        logic        rs2_used;
        logic        rd_wen;
        logic        illegal;
    } lane_t;

    typedef struct packed {
        logic [LANES-1:0]  lane_valid;
        lane_t [LANES-1:0] lane;
    } beat_t;

    function automatic lane_t decode_lane(input logic [31:0] instn,
                                          input logic [31:0] pc,
                                          input logic        lane_vld);
        lane_t      d;
        logic       known;
        logic       bad_fn;
        logic       uses_rs1;
        logic       uses_rs2;
        logic       writes_rd;
        logic       illegal;
        logic [2:0] f3;
        logic [6:0] f7;

        f3 = instn[14:12];
        f7 = instn[31:25];

        d          = '0;
        d.pc       = pc;
        d.op       = instn[6:0];
        d.funct3   = f3;
        d.funct7   = f7;
        d.rs1      = instn[19:15];
        d.rs2      = instn[24:20];
        d.rd       = instn[11:7];
        d.imm_type = IMM_R;

        known     = 1'b1;
        bad_fn    = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;

        case (instn[6:0])
            OPC_LOAD: begin
                d.imm_type = IMM_I;
                uses_rs1   = 1'b1;
                writes_rd  = 1'b1;
                bad_fn     = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_OP_IMM: begin
                d.imm_type = IMM_I;
                uses_rs1   = 1'b1;
                writes_rd  = 1'b1;
                // Only the shift encodings constrain funct7; SRAI is the lone alt form.
                if (f3 == 3'b001) begin
                    bad_fn = (f7 != F7_ZERO);
                end else if (f3 == 3'b101) begin
                    bad_fn = (f7 != F7_ZERO) && (f7 != F7_ALT);
                end
            end
            OPC_JALR: begin
                d.imm_type = IMM_I;
                uses_rs1   = 1'b1;
                writes_rd  = 1'b1;
                bad_fn     = (f3 != 3'b000);
            end
            OPC_SYSTEM: begin
                d.imm_type = IMM_I;
            end
            OPC_STORE: begin
                d.imm_type = IMM_S;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                bad_fn     = (f3 > 3'b010);
            end
            OPC_BRANCH: begin
                d.imm_type = IMM_B;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
                bad_fn     = (f3 == 3'b010) || (f3 == 3'b011);
            end
            OPC_LUI, OPC_AUIPC: begin
                d.imm_type = IMM_U;
                writes_rd  = 1'b1;
            end
            OPC_JAL: begin
                d.imm_type = IMM_J;
                writes_rd  = 1'b1;
            end
            OPC_OP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
                // SUB and SRA are the only funct7=0100000 forms.
                bad_fn    = !((f7 == F7_ZERO) ||
                              ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_FENCE: begin
            end
            default: begin
                known = 1'b0;
            end
        endcase

        illegal = (instn[1:0] != 2'b11) || !known || (ILLEGAL_CHK && bad_fn);

        if (illegal) begin
            d.imm_type = IMM_R;
        end

        case (d.imm_type)
            IMM_I:   d.imm = {{20{instn[31]}}, instn[31:20]};
            IMM_S:   d.imm = {{20{instn[31]}}, instn[31:25], instn[11:7]};
            IMM_B:   d.imm = {{19{instn[31]}}, instn[31], instn[7], instn[30:25],
                              instn[11:8], 1'b0};
            IMM_U:   d.imm = {instn[31:12], 12'b0};
            IMM_J:   d.imm = {{11{instn[31]}}, instn[31], instn[19:12], instn[20],
                              instn[30:21], 1'b0};
            default: d.imm = '0;
        endcase

        d.illegal  = lane_vld && illegal;
        d.rs1_used = lane_vld && !illegal && uses_rs1;
        d.rs2_used = lane_vld && !illegal && uses_rs2;
        d.rd_wen   = lane_vld && !illegal && writes_rd && (instn[11:7] != 5'd0);
        return d;
    endfunction

    beat_t in_beat;
    beat_t m_q, m_d;
    beat_t s_q, s_d;
    logic  m_valid_q, m_valid_d;
    logic  s_valid_q, s_valid_d;
    logic  in_ready_q, in_ready_d;
    logic  accept;
    logic  drain;

    always_comb begin
        in_beat            = '0;
        in_beat.lane_valid = bus.in_lane_valid;
        for (int k = 0; k < LANES; k++) begin
            in_beat.lane[k] = decode_lane(bus.in_instn[32*k +: 32],
                                          bus.in_pc + 32'(4 * k),
                                          bus.in_lane_valid[k]);
        end
    end

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = m_valid_q & bus.out_ready;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;

        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (drain) begin
            // in_ready is low whenever S holds a beat, so S->M and accept never coincide.
            if (s_valid_q) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_d = in_beat;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q) begin
                m_d       = in_beat;
                m_valid_d = 1'b1;
            end else begin
                s_d       = in_beat;
                s_valid_d = 1'b1;
            end
        end

        in_ready_d = !s_valid_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q        <= '0;
            s_q        <= '0;
            m_valid_q  <= 1'b0;
            s_valid_q  <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            m_q        <= m_d;
            s_q        <= s_d;
            m_valid_q  <= m_valid_d;
            s_valid_q  <= s_valid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready       = in_ready_q;
    assign bus.out_valid      = m_valid_q;
    assign bus.out_lane_valid = m_q.lane_valid;

    for (genvar k = 0; k < LANES; k++) begin : g_out
        assign bus.out_pc[32*k +: 32]      = m_q.lane[k].pc;
        assign bus.out_op[7*k +: 7]        = m_q.lane[k].op;
        assign bus.out_funct3[3*k +: 3]    = m_q.lane[k].funct3;
        assign bus.out_funct7[7*k +: 7]    = m_q.lane[k].funct7;
        assign bus.out_rs1[5*k +: 5]       = m_q.lane[k].rs1;
        assign bus.out_rs2[5*k +: 5]       = m_q.lane[k].rs2;
        assign bus.out_rd[5*k +: 5]        = m_q.lane[k].rd;
        assign bus.out_imm[32*k +: 32]     = m_q.lane[k].imm;
        assign bus.out_imm_type[3*k +: 3]  = m_q.lane[k].imm_type;
        assign bus.out_rs1_used[k]         = m_q.lane[k].rs1_used;
        assign bus.out_rs2_used[k]         = m_q.lane[k].rs2_used;
        assign bus.out_rd_wen[k]           = m_q.lane[k].rd_wen;
        assign bus.out_illegal[k]          = m_q.lane[k].illegal;
    end

endmodule

// File: doc/instn_decode_pipe.md
# instn_decode_pipe

Parametrised, registered RV32I decode stage for the ID pipeline slot. It accepts a bundle of `LANES` fetched instructions per handshake and produces fully decoded fields per lane, including a single format-selected sign-extended immediate, register-use flags and an illegal-instruction flag. Input and output use valid/ready handshakes, with a 2-entry skid buffer so that `in_ready` is a register output. A synchronous flush supports branch redirect.

## Interface
- `LANES`, 1: instructions decoded per beat (1..4).
- `ILLEGAL_CHK`, 1: 1 enables the full funct3/funct7 legality checks; 0 checks opcode only.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous kill of all buffered beats.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: stage can accept a beat.
- `in_lane_valid` in LANES: per-lane valid mask within the beat.
- `in_instn` in 32*LANES: lane k occupies bits [32k+31:32k].
- `in_pc` in 32: PC of lane 0. Lane k PC is `in_pc + 4k`, mod 2^32.
- `out_valid` out 1: decoded beat valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_lane_valid` out LANES: registered copy of the lane mask.
- `out_pc` out 32*LANES: per-lane PC.
- `out_op` out 7*LANES: per-lane opcode.
- `out_funct3` out 3*LANES: per-lane funct3.
- `out_funct7` out 7*LANES: per-lane funct7.
- `out_rs1` out 5*LANES: per-lane rs1.
- `out_rs2` out 5*LANES: per-lane rs2.
- `out_rd` out 5*LANES: per-lane rd.
- `out_imm` out 32*LANES: sign-extended immediate for the lane's format.
- `out_imm_type` out 3*LANES: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J.
- `out_rs1_used` out LANES: lane reads rs1.
- `out_rs2_used` out LANES: lane reads rs2.
- `out_rd_wen` out LANES: lane writes rd.
- `out_illegal` out LANES: lane holds an illegal instruction.

## Operation
- **Field extraction.** op = [6:0], funct3 = [14:12], funct7 = [31:25], rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- **Immediate selection by opcode.**
  - I: `{20{i[31]}, i[31:20]}`, for LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011.
  - S: `{20{i[31]}, i[31:25], i[11:7]}`, for STORE 0100011.
  - B: `{19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}`, for BRANCH 1100011.
  - U: `{i[31:12], 12'b0}`, for LUI 0110111 and AUIPC 0010111.
  - J: `{11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}`, for JAL 1101111.
  - R/none: imm = 0, for OP 0110011, FENCE 0001111 and illegal lanes.
- **Register-use flags.**
  - `rs1_used`: OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - `rs2_used`: OP, STORE, BRANCH.
  - `rd_wen`: LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and only when rd != 0.
- **Illegal conditions** (always checked):
  - i[1:0] != 2'b11.
  - opcode not in the list above.
- **Illegal conditions** (only when `ILLEGAL_CHK` = 1):
  - BRANCH with funct3 010 or 011.
  - LOAD with funct3 011, 110 or 111.
  - STORE with funct3 > 010.
  - JALR with funct3 != 0.
  - OP with funct7 not 0000000, or 0100000 with funct3 other than 000/101.
  - OP-IMM shifts (funct3 001/101) with funct7 not 0000000, or 0100000 with funct3 other than 101.
- **Illegal-lane outputs.** An illegal lane has `rs1_used`, `rs2_used` and `rd_wen` forced to 0. Its raw fields pass through unchanged.
- **Invalid-lane outputs.** A lane with `in_lane_valid` = 0 outputs `illegal`, `rd_wen`, `rs1_used` and `rs2_used` = 0. Its other fields are don't-care.
- **Buffering.** Decode is combinational on the input. Results are stored in the main register (M), with skid register S behind it.
  - `in_ready` = !S.valid.
  - Accept happens when `in_valid & in_ready`. The beat goes into M if M is empty or M is draining this cycle; otherwise it goes into S.
  - When M drains (`out_valid & out_ready`) and S is valid, S moves to M.
  - Order is preserved; no beat is dropped or duplicated.
- **Flush** has priority over all other events. At the next edge M.valid = S.valid = 0, and any beat presented in the flush cycle is discarded.

## Timing
- **Reset state.** All valid bits are 0, all data registers are 0, all outputs read 0, and `in_ready` = 1.
- **Latency.** 1 cycle: a beat accepted at edge n appears on `out_*` after edge n.
- **Throughput.** 1 beat per cycle while `out_ready` = 1.
- **Stall.** `in_ready` falls one cycle after `out_ready` deasserts with M full and a new beat accepted (i.e. S fills). It rises the cycle after S empties.
- **Output stability.** `out_*` holds stable while `out_valid & !out_ready`.
- **Simultaneous events.**
  - Accept and drain with S empty: the new beat replaces M.
  - Flush with accept: the input is dropped.
  - Reset mid-operation: asynchronous clear to the reset state.

## Test plan
- **Single-lane legality.** LANES=1, `addi x5,x0,-1` (0xFFF00293) -> one cycle later imm=0xFFFFFFFF, type 1, rd=5, rd_wen=1, rs1_used=1, illegal=0.
- **Format immediates.** `jal x1,-4` (0xFFDFF0EF) -> imm=0xFFFFFFFC, type 5. `sw x2,8(x3)` (0x0021A423) -> imm=8, type 2, rd_wen=0, rs2_used=1.
- **Illegal detection.** 0x00000000 -> illegal=1, rd_wen=0. `sub` with funct3=001 (0x40001033) -> illegal=1 when ILLEGAL_CHK=1, 0 when ILLEGAL_CHK=0.
- **Multi-lane.** LANES=4, in_pc=0xFFFFFFF8, mask 4'b1011 -> out_pc = {0x4, 0x0, 0xFFFFFFFC, 0xFFFFFFF8}, lane 2 flags all 0.
- **Backpressure.** Stream 6 beats with `out_ready` held low for 3 cycles -> `in_ready` drops after 2 beats are buffered, and all 6 beats emerge in order.
- **Flush and reset.** Flush with M and S full plus an input beat -> out_valid=0 next cycle and in_ready=1. Assert reset_n=0 mid-stream -> outputs go to 0 immediately.
